// File: rtl/wb_reg_file_if.sv
// MEM/WB writeback and decode read-port bundle for the ARM register file.
// The master side is the pipeline/decode logic; the slave side is wb_reg_file.
interface wb_reg_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  reg_write_enable_in;
  logic                  mem_to_reg_select_in;
  logic [ADDR_WIDTH-1:0] wb_rd_in;
  logic [DATA_WIDTH-1:0] alu_result_in;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] pc_plus8_in;
  logic [ADDR_WIDTH-1:0] rn_addr;
  logic [ADDR_WIDTH-1:0] rm_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rn_data;
  logic [DATA_WIDTH-1:0] rm_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wb_data_out;
  logic                  wb_commit;

  modport master (
    output reg_write_enable_in, mem_to_reg_select_in, wb_rd_in, alu_result_in, mem_data_in,
    output pc_plus8_in, rn_addr, rm_addr, rd_addr,
    input  rn_data, rm_data, rd_data, wb_data_out, wb_commit
  );

  modport slave (
    input  reg_write_enable_in, mem_to_reg_select_in, wb_rd_in, alu_result_in, mem_data_in,
    input  pc_plus8_in, rn_addr, rm_addr, rd_addr,
    output rn_data, rm_data, rd_data, wb_data_out, wb_commit
  );
endinterface

// File: rtl/wb_reg_file.sv
// ARM architectural register file at the MEM/WB boundary: writeback select, commit,
// and three combinational read ports with same-cycle bypass; R15 reads return PC+8.
module wb_reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned PC_INDEX   = 15
) (
  input logic         clk,
  input logic         reset,
  wb_reg_file_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] PcAddr = ADDR_WIDTH'(PC_INDEX);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wb_commit_q;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  bypass_en;
  logic [ADDR_WIDTH-1:0] raddr [3];
  logic [DATA_WIDTH-1:0] rdata [3];

  assign wb_data   = bus.mem_to_reg_select_in ? bus.mem_data_in : bus.alu_result_in;
  // A write held off by reset must not leak through the bypass either.
  assign bypass_en = bus.reg_write_enable_in && !reset;

  assign raddr[0] = bus.rn_addr;
  assign raddr[1] = bus.rm_addr;
  assign raddr[2] = bus.rd_addr;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = '0;
      if (raddr[p] == PcAddr) begin
        rdata[p] = bus.pc_plus8_in;
      end else if (reset) begin
        rdata[p] = '0;
      end else if (bypass_en && (raddr[p] == bus.wb_rd_in)) begin
        rdata[p] = wb_data;
      end else begin
        rdata[p] = regs_q[raddr[p]];
      end
    end
  end

  // R15 storage is never written; PC updates belong to fetch/branch logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_commit_q <= 1'b0;
    end else begin
      if (bus.reg_write_enable_in && (bus.wb_rd_in != PcAddr)) begin
        regs_q[bus.wb_rd_in] <= wb_data;
      end
      wb_commit_q <= bus.reg_write_enable_in;
    end
  end

  assign bus.rn_data     = rdata[0];
  assign bus.rm_data     = rdata[1];
  assign bus.rd_data     = rdata[2];
  assign bus.wb_data_out = wb_data;
  assign bus.wb_commit   = wb_commit_q;
endmodule
